// File: rtl/calc_pkg.sv
// Shared widths and result types for the adder core, its result buffer and the co-emulation bench.
package calc_pkg;

  localparam int unsigned SUM_W = 9;
  localparam int unsigned RES_W = 8;

  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [RES_W-1:0] res_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != '1)) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sum_result_buffer.sv
// Fall-through FIFO for adder results with valid/ready drain, plus drop and carry statistics.
module sum_result_buffer
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  sum_t                     in_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output res_t                     out_z,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         carry_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  sum_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, drop;

  // Status is derived from count_q only, never from the live handshake inputs.
  assign full      = (count_q == DepthCnt);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign out_valid = !empty;
  assign {out_carry, out_z} = mem_q[rd_ptr_q];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; its contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_z;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .value (drop_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_carry_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (push && in_z[SUM_W-1]),
    .value (carry_cnt)
  );

endmodule
